// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package shifter_pkg;

    // Operation select carried alongside each operand through the pipeline.
    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRA = 2'b01,
        MODE_ROR = 2'b10,
        MODE_SRL = 2'b11
    } mode_t;

endpackage

// File: rtl/shift_stage.sv
// One registered log-shift stage: shifts by 2**K when shamt[K] is set.
// Latency: 1 cycle.
// Backpressure: in_ready = !out_valid || out_ready; holds payload while stalled.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       upstream handshake
//   in_data/in_shamt/in_mode/in_carry    payload from the previous stage
//   out_valid/out_ready     downstream handshake
//   out_data/out_shamt/out_mode/out_carry registered payload to the next stage
module shift_stage
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 16,
    parameter  int K       = 0,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  mode_t              in_mode,
    input  logic               in_carry,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output mode_t              out_mode,
    output logic               out_carry
);

    localparam int S = 1 << K;

    logic [WIDTH-1:0] shifted;
    logic             shift_carry;

    // The carry is the last bit to cross the edge in this stage. SRA keeps
    // bit WIDTH-1 intact in every stage, so the original sign survives to
    // later stages without being carried separately. For ROR the carry is
    // the new MSB, which is the old bit S-1. An inactive stage passes the
    // incoming carry through so the last active stage decides it.
    always_comb begin
        shifted     = in_data;
        shift_carry = in_carry;
        if (in_shamt[K]) begin
            case (in_mode)
                MODE_SLL: begin
                    shifted     = in_data << S;
                    shift_carry = in_data[WIDTH-S];
                end
                MODE_SRA: begin
                    shifted     = $signed(in_data) >>> S;
                    shift_carry = in_data[S-1];
                end
                MODE_ROR: begin
                    shifted     = (in_data >> S) | (in_data << (WIDTH - S));
                    shift_carry = in_data[S-1];
                end
                default: begin
                    shifted     = in_data >> S;
                    shift_carry = in_data[S-1];
                end
            endcase
        end
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_mode  <= MODE_SLL;
            out_carry <= 1'b0;
        end else if (in_ready) begin
            // An empty slot upstream becomes a bubble here; payload only
            // moves on a real transfer.
            out_valid <= in_valid;
            if (in_valid) begin
                out_data  <= shifted;
                out_shamt <= in_shamt;
                out_mode  <= in_mode;
                out_carry <= shift_carry;
            end
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRA/ROR/SRL) with carry-out and zero flag.
// Latency: SHAMT_W = $clog2(WIDTH) cycles (4 at WIDTH=16), one result per cycle.
// Backpressure: per-stage valid/ready; bubbles collapse, output held while !out_ready.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   in_valid/in_ready               operand handshake (in_ready has no in_valid path)
//   in_data, in_shamt, in_mode      operand, shift amount, 00 SLL 01 SRA 10 ROR 11 SRL
//   out_valid/out_ready             result handshake
//   out_data, out_carry, out_zero   result, last bit shifted out, result == 0
// WIDTH must be a power of two and at least 4.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH   = 16,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_carry,
    output logic               out_zero
);

    // Index k is the boundary feeding stage k; index SHAMT_W is the output.
    logic               st_valid [0:SHAMT_W];
    logic               st_ready [0:SHAMT_W];
    logic [WIDTH-1:0]   st_data  [0:SHAMT_W];
    logic [SHAMT_W-1:0] st_shamt [0:SHAMT_W];
    mode_t              st_mode  [0:SHAMT_W];
    logic               st_carry [0:SHAMT_W];

    assign st_valid[0]       = in_valid;
    assign st_data[0]        = in_data;
    assign st_shamt[0]       = in_shamt;
    assign st_mode[0]        = mode_t'(in_mode);
    assign st_carry[0]       = 1'b0;
    assign st_ready[SHAMT_W] = out_ready;
    assign in_ready          = st_ready[0];

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (st_valid[k]),
            .in_ready  (st_ready[k]),
            .in_data   (st_data[k]),
            .in_shamt  (st_shamt[k]),
            .in_mode   (st_mode[k]),
            .in_carry  (st_carry[k]),
            .out_valid (st_valid[k+1]),
            .out_ready (st_ready[k+1]),
            .out_data  (st_data[k+1]),
            .out_shamt (st_shamt[k+1]),
            .out_mode  (st_mode[k+1]),
            .out_carry (st_carry[k+1])
        );
    end

    assign out_valid = st_valid[SHAMT_W];
    assign out_data  = st_data[SHAMT_W];
    assign out_carry = st_carry[SHAMT_W];
    assign out_zero  = (out_data == '0);

    // Shift amount and mode are fully consumed by the last stage.
    logic unused_tail;
    assign unused_tail = ^{st_shamt[SHAMT_W], st_mode[SHAMT_W]};

endmodule

// File: tb/tb_pipe_shifter.sv
module tb_pipe_shifter;
    import shifter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;          // 0 = 16-bit instance active, 1 = 32-bit
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        out_ready;

    logic        rdy16, ov16, oc16, oz16;
    logic [15:0] od16;
    logic        rdy32, ov32, oc32, oz32;
    logic [31:0] od32;

    always #5 clk = ~clk;

    pipe_shifter #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(rdy16),
        .in_data(in_data[15:0]), .in_shamt(in_shamt[3:0]), .in_mode(in_mode),
        .out_valid(ov16), .out_ready(out_ready), .out_data(od16),
        .out_carry(oc16), .out_zero(oz16)
    );

    pipe_shifter #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(rdy32),
        .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
        .out_valid(ov32), .out_ready(out_ready), .out_data(od32),
        .out_carry(oc32), .out_zero(oz32)
    );

    logic        m_valid, m_ready, m_carry, m_zero;
    logic [31:0] m_data;
    assign m_valid = sel ? ov32 : ov16;
    assign m_ready = sel ? rdy32 : rdy16;
    assign m_carry = sel ? oc32 : oc16;
    assign m_zero  = sel ? oz32 : oz16;
    assign m_data  = sel ? od32 : {16'd0, od16};

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: result of shifting a w-bit operand by sh under the
    // mode's fill/rotate rules; carry is the last bit to leave the word.
    function automatic logic [32:0] model(input int w, input logic [31:0] d,
                                          input int sh, input logic [1:0] m);
        logic [63:0] mask, x, r;
        logic        c;
        mask = (64'd1 << w) - 64'd1;
        x    = {32'd0, d} & mask;
        if (sh == 0) return {1'b0, x[31:0]};
        case (m)
            2'b00: begin r = (x << sh) & mask; c = x[w - sh]; end
            2'b01: begin
                r = x >> sh;
                if (x[w-1]) r = r | (mask & ~(mask >> sh));
                c = x[sh - 1];
            end
            2'b10: begin r = ((x >> sh) | (x << (w - sh))) & mask; c = r[w-1]; end
            default: begin r = x >> sh; c = x[sh - 1]; end
        endcase
        return {c, r[31:0]};
    endfunction

    typedef struct {
        logic [31:0] d;
        logic        c;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          pops = 0;
    int          outs = 0;
    int          accepted = 0;
    int          pop_cyc[0:1023];
    logic        fire_n = 1'b0;
    logic        lat_chk = 1'b1;
    logic        hold = 1'b0;
    logic [31:0] hold_d;
    logic        hold_c;
    logic [31:0] last_d;
    logic        last_c, last_z;

    // Compare process: scoreboard against the model, one look per cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [32:0] r;
        cyc++;
        fire_n = 1'b0;
        if (!rst_n) begin
            q.delete();
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", m_data, hold_d);
                chk("hold_carry", {31'd0, m_carry}, {31'd0, hold_c});
            end
            if (m_valid && out_ready) begin
                outs++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output: got data 0x%0h with nothing expected at %0t", m_data, $time);
                end else begin
                    e = q.pop_front();
                    chk("out_data", m_data, e.d);
                    chk("out_carry", {31'd0, m_carry}, {31'd0, e.c});
                    chk("out_zero", {31'd0, m_zero}, {31'd0, (e.d == 32'd0)});
                    if (lat_chk) chk("latency", cyc - e.cyc, sel ? 32'd5 : 32'd4);
                    last_d = m_data;
                    last_c = m_carry;
                    last_z = m_zero;
                    pop_cyc[pops % 1024] = cyc;
                    pops++;
                end
            end
            hold   = m_valid && !out_ready;
            hold_d = m_data;
            hold_c = m_carry;
            fire_n = in_valid && m_ready;
            if (fire_n) begin
                r = model(sel ? 32 : 16, in_data, int'(in_shamt), in_mode);
                e.d = r[31:0];
                e.c = r[32];
                e.cyc = cyc;
                q.push_back(e);
                accepted++;
            end
        end
    end

    // Driver tasks are entered and left 1 time unit after a rising edge.
    task automatic send(input logic [31:0] d, input int sh, input logic [1:0] m);
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = 5'(sh);
        in_mode  = m;
        for (int t = 0; t < 100 && !done; t++) begin
            @(posedge clk);
            done = fire_n;
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for 100 cycles, required 1");
        end
    endtask

    task automatic send_rand();
        send($urandom, $urandom_range(0, sel ? 31 : 15), 2'($urandom_range(0, 3)));
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && q.size() != 0; t++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic op_lit(input string name, input logic [31:0] d, input int sh,
                          input logic [1:0] m, input logic [31:0] ed, input logic ec);
        send(d, sh, m);
        drain();
        chk({name, "_data"}, last_d, ed);
        chk({name, "_carry"}, {31'd0, last_c}, {31'd0, ec});
        chk({name, "_zero"}, {31'd0, last_z}, {31'd0, (ed == 32'd0)});
    endtask

    task automatic stream(input int n);
        int p0 = pops;
        for (int i = 0; i < n; i++) send_rand();
        drain();
        chk("stream_count", pops - p0, n);
        if (pops - p0 == n)
            chk("stream_consecutive", pop_cyc[(p0 + n - 1) % 1024] - pop_cyc[p0 % 1024], n - 1);
    endtask

    initial begin
        int a0, p0, o0;
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_data = '0;
        in_shamt = '0; in_mode = 2'b00; out_ready = 1'b1;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid16", {31'd0, ov16}, 32'd0);
        chk("rst_data16", {16'd0, od16}, 32'd0);
        chk("rst_zero16", {31'd0, oz16}, 32'd1);
        chk("rst_carry16", {31'd0, oc16}, 32'd0);
        chk("rst_valid32", {31'd0, ov32}, 32'd0);
        chk("rst_data32", od32, 32'd0);
        chk("rst_zero32", {31'd0, oz32}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready16", {31'd0, rdy16}, 32'd1);
        chk("rst_ready32", {31'd0, rdy32}, 32'd1);
        @(posedge clk);
        #1;

        // Directed 16-bit operations.
        op_lit("sll1", 32'h8001, 1, MODE_SLL, 32'h0002, 1'b1);
        op_lit("sra1", 32'h8001, 1, MODE_SRA, 32'hC000, 1'b1);
        op_lit("srl1", 32'h8001, 1, MODE_SRL, 32'h4000, 1'b1);
        op_lit("ror4", 32'h8001, 4, MODE_ROR, 32'h1800, 1'b0);

        // Boundaries.
        op_lit("sh0", 32'hA5C3, 0, MODE_SRA, 32'hA5C3, 1'b0);
        op_lit("sra15", 32'h8000, 15, MODE_SRA, 32'hFFFF, 1'b0);
        op_lit("sll15", 32'h0001, 15, MODE_SLL, 32'h8000, 1'b0);
        op_lit("srl15", 32'h7FFF, 15, MODE_SRL, 32'h0000, 1'b1);

        // Streaming.
        stream(20);

        // Backpressure from an empty pipe: four entries fill it, then stall.
        lat_chk = 1'b0;
        a0 = accepted;
        p0 = pops;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_rand();
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("bp_accepted", accepted - a0, 32'd4);
                chk("bp_in_ready", {31'd0, m_ready}, 32'd0);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_total", pops - p0, 32'd8);
        lat_chk = 1'b1;

        // Reset with three operations in flight.
        send(32'h1111, 1, MODE_SLL);
        send(32'h2222, 2, MODE_SRL);
        send(32'h3333, 3, MODE_ROR);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        o0 = outs;
        idle(8);
        chk("reset_dropped", outs - o0, 32'd0);
        op_lit("post_reset", 32'h1234, 4, MODE_SRL, 32'h0123, 1'b0);

        // 32-bit instance.
        sel = 1'b1;
        op_lit("w32_sll1", 32'h8000_0001, 1, MODE_SLL, 32'h0000_0002, 1'b1);
        op_lit("w32_ror4", 32'h8000_0001, 4, MODE_ROR, 32'h1800_0000, 1'b0);
        op_lit("w32_sra31", 32'h8000_0000, 31, MODE_SRA, 32'hFFFF_FFFF, 1'b0);
        stream(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
